// File: rtl/sync_fifo_ff_pad.sv
// sync_fifo_ff_pad: synchronous FIFO between the FF-escape stage and the
// bitstream packer. Each accepted write stores one data word and reserves
// up to MAX_SKIP tagged pad slots behind it. The packer uses those slots as
// spare cycles for stuffed 0x00 bytes, and it discards any word read back
// with rd_pad=1.
// Optional feature: define SYNC_FIFO_FF_PAD_ERR_EN to build the sticky
// ovf_err/udf_err flags. When it is not defined, both flags are tied low.
module sync_fifo_ff_pad #(
  parameter  int WIDTH        = 91,
  parameter  int DEPTH        = 16,
  parameter  int MAX_SKIP     = 1,
  parameter  int AFULL_THRESH = 12,
  localparam int AW           = $clog2(DEPTH),
  localparam int SW           = $clog2(MAX_SKIP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [SW-1:0]    wr_skip,
  output logic             wr_accept,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_pad,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [AW:0]      level,
  output logic             ovf_err,
  output logic             udf_err
);

  localparam logic [SW-1:0] MAX_SKIP_V = SW'(MAX_SKIP);
  localparam logic [AW:0]   DEPTH_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_LVL  = (AW+1)'(AFULL_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pad;
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [SW-1:0]    skip;
  logic [AW+1:0]    free_slots;
  logic [AW+1:0]    need_slots;
  logic             rd_en;

  assign waddr = wptr[AW-1:0];
  assign raddr = rptr[AW-1:0];

  // Status flags come straight from the pointers, so they follow every event by one cycle.
  assign level       = wptr - rptr;
  assign empty       = (level == '0);
  assign full        = (level == DEPTH_LVL);
  assign almost_full = (level >= AFULL_LVL);

  // Clamp the requested pad count. Acceptance uses the level at the start of
  // the cycle, so a read in the same cycle does not free space for the write.
  assign skip       = (wr_skip > MAX_SKIP_V) ? MAX_SKIP_V : wr_skip;
  assign free_slots = (AW+2)'(DEPTH) - {1'b0, level};
  assign need_slots = (AW+2)'(skip) + (AW+2)'(1);
  assign wr_accept  = wr_en && (free_slots >= need_slots);
  assign rd_en      = rd_req && !empty;

  // Data RAM: one write port, not reset; only the data word is stored, never the pads.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[waddr] <= wr_data;
    end
  end

  // Pad tags: clear the tag under the data word, then set tags on the reserved slots behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad <= '0;
    end else if (wr_accept) begin
      pad[waddr] <= 1'b0;
      for (int i = 1; i <= MAX_SKIP; i++) begin
        if (SW'(i) <= skip) begin
          pad[waddr + AW'(i)] <= 1'b1;
        end
      end
    end
  end

  // Pointers: a write advances past its data word and all of its pads; every read, pad or not, costs one slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_accept) begin
        wptr <= wptr + (AW+1)'(1) + (AW+1)'(skip);
      end
      if (rd_en) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

  // Registered read port: rd_valid pulses for one cycle per read, and rd_data/rd_pad hold in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_pad   <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[raddr];
        rd_pad  <= pad[raddr];
      end
    end
  end

`ifdef SYNC_FIFO_FF_PAD_ERR_EN
  // Sticky error flags: a refused write or a read on empty latches until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_en && !wr_accept) begin
        ovf_err <= 1'b1;
      end
      if (rd_req && empty) begin
        udf_err <= 1'b1;
      end
    end
  end
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ff_pad.sv
// Directed bench for sync_fifo_ff_pad. Expected values are worked out by
// hand, except in the random wrap test, which checks against a small queue
// model. Set SYNC_FIFO_FF_PAD_ERR_EN to match the build of the RTL.
module tb_sync_fifo_ff_pad;

  localparam int WIDTH = 91;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SW    = 1;
`ifdef SYNC_FIFO_FF_PAD_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [SW-1:0]    wr_skip;
  logic             wr_accept;
  logic             rd_req;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_pad;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [AW:0]      level;
  logic             ovf_err;
  logic             udf_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             is_pad;
    logic [WIDTH-1:0] data;
  } slot_t;
  slot_t model_q[$];

  sync_fifo_ff_pad #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_SKIP(1), .AFULL_THRESH(12)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_skip(wr_skip),
    .wr_accept(wr_accept), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_pad(rd_pad), .empty(empty), .full(full), .almost_full(almost_full),
    .level(level), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log any miss.
  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs; they settle well before the next rising edge.
  task automatic apply_stimulus(input logic we, input logic [WIDTH-1:0] d,
                                input logic [SW-1:0] sk, input logic rr);
    wr_en   = we;
    wr_data = d;
    wr_skip = sk;
    rd_req  = rr;
    #1;
  endtask

  // Clock the applied inputs in, then idle the inputs 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_skip = '0;
    rd_req  = 1'b0;
  endtask

  // Pop one word and check the data (skipped for pads) and the pad tag.
  task automatic read_check(input string tag, input logic [WIDTH-1:0] exp_d, input logic exp_pad);
    apply_stimulus(1'b0, '0, '0, 1'b1);
    tick();
    check_output({tag, "_valid"}, 128'(rd_valid), 128'(1'b1));
    check_output({tag, "_pad"}, 128'(rd_pad), 128'(exp_pad));
    if (!exp_pad) check_output({tag, "_data"}, 128'(rd_data), 128'(exp_d));
  endtask

  initial begin
    logic             exp_acc;
    logic             do_wr;
    logic             do_rd;
    logic             rd_go;
    logic [SW-1:0]    sk;
    slot_t            head;
    logic [WIDTH-1:0] wd;

    rst = 1'b1;
    wr_en = 1'b0; wr_data = '0; wr_skip = '0; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset state");
    check_output("rst_level", 128'(level), 128'(0));
    check_output("rst_empty", 128'(empty), 128'(1));
    check_output("rst_full", 128'(full), 128'(0));
    check_output("rst_afull", 128'(almost_full), 128'(0));
    check_output("rst_rdv", 128'(rd_valid), 128'(0));
    check_output("rst_rdata", 128'(rd_data), 128'(0));
    check_output("rst_ovf", 128'(ovf_err), 128'(0));
    check_output("rst_udf", 128'(udf_err), 128'(0));

    $display("[TB] T1 plain words");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, WIDTH'(8'hA1 + i), '0, 1'b0);
      check_output("t1_acc", 128'(wr_accept), 128'(1));
      tick();
    end
    check_output("t1_level4", 128'(level), 128'(4));
    for (int i = 0; i < 4; i++) read_check("t1_rd", WIDTH'(8'hA1 + i), 1'b0);
    check_output("t1_empty", 128'(empty), 128'(1));
    tick();
    check_output("t1_rdv_idle", 128'(rd_valid), 128'(0));

    $display("[TB] T2 pad slots");
    apply_stimulus(1'b1, WIDTH'(8'h55), 1'b1, 1'b0);
    tick();
    check_output("t2_level2", 128'(level), 128'(2));
    apply_stimulus(1'b1, WIDTH'(8'h66), 1'b0, 1'b0);
    tick();
    check_output("t2_level3", 128'(level), 128'(3));
    read_check("t2_rd0", WIDTH'(8'h55), 1'b0);
    read_check("t2_rd1", '0, 1'b1);
    read_check("t2_rd2", WIDTH'(8'h66), 1'b0);
    check_output("t2_level0", 128'(level), 128'(0));

    $display("[TB] T3 fill and overflow");
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(1'b1, WIDTH'(12'h300 + i), '0, 1'b0);
      tick();
    end
    check_output("t3_level15", 128'(level), 128'(15));
    check_output("t3_afull", 128'(almost_full), 128'(1));
    check_output("t3_notfull", 128'(full), 128'(0));
    apply_stimulus(1'b1, WIDTH'(12'hBAD), 1'b1, 1'b0);
    check_output("t3_refuse", 128'(wr_accept), 128'(0));
    tick();
    check_output("t3_level_held", 128'(level), 128'(15));
    check_output("t3_ovf", 128'(ovf_err), 128'(ERR_ON));
    apply_stimulus(1'b1, WIDTH'(12'h30F), 1'b0, 1'b0);
    check_output("t3_accept_last", 128'(wr_accept), 128'(1));
    tick();
    check_output("t3_full", 128'(full), 128'(1));
    check_output("t3_level16", 128'(level), 128'(16));

    $display("[TB] T4 simultaneous read and write");
    apply_stimulus(1'b1, WIDTH'(12'hCCC), '0, 1'b1);
    check_output("t4_full_refuse", 128'(wr_accept), 128'(0));
    tick();
    check_output("t4_rdv", 128'(rd_valid), 128'(1));
    check_output("t4_rdata", 128'(rd_data), 128'(12'h300));
    check_output("t4_level15", 128'(level), 128'(15));
    for (int i = 1; i < 8; i++) read_check("t4_drain", WIDTH'(12'h300 + i), 1'b0);
    check_output("t4_level8", 128'(level), 128'(8));
    apply_stimulus(1'b1, WIDTH'(12'h4A4), '0, 1'b1);
    check_output("t4_mid_accept", 128'(wr_accept), 128'(1));
    tick();
    check_output("t4_mid_rdata", 128'(rd_data), 128'(12'h308));
    check_output("t4_level_still8", 128'(level), 128'(8));
    for (int i = 9; i < 16; i++) read_check("t4_tail", WIDTH'(12'h300 + i), 1'b0);
    read_check("t4_last", WIDTH'(12'h4A4), 1'b0);
    check_output("t4_empty", 128'(empty), 128'(1));

    $display("[TB] T5 random skips across pointer wrap");
    for (int n = 0; n < 40; n++) begin
      do_wr = ($urandom_range(0, 9) < 6);
      do_rd = ($urandom_range(0, 9) < 4);
      sk    = SW'($urandom_range(0, 1));
      wd    = WIDTH'(16'h5000 + n);
      exp_acc = do_wr && ((DEPTH - model_q.size()) >= (1 + int'(sk)));
      rd_go   = do_rd && (model_q.size() > 0);
      apply_stimulus(do_wr, wd, sk, do_rd);
      check_output("t5_acc", 128'(wr_accept), 128'(exp_acc));
      tick();
      if (rd_go) begin
        head = model_q.pop_front();
        check_output("t5_rdv", 128'(rd_valid), 128'(1));
        check_output("t5_pad", 128'(rd_pad), 128'(head.is_pad));
        if (!head.is_pad) check_output("t5_data", 128'(rd_data), 128'(head.data));
      end else begin
        check_output("t5_rdv_idle", 128'(rd_valid), 128'(0));
      end
      if (exp_acc) begin
        model_q.push_back('{is_pad: 1'b0, data: wd});
        if (sk != '0) model_q.push_back('{is_pad: 1'b1, data: '0});
      end
      check_output("t5_level", 128'(level), 128'(model_q.size()));
      check_output("t5_afull", 128'(almost_full), 128'(model_q.size() >= 12));
    end

    $display("[TB] T6 reset mid-burst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete();
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, WIDTH'(12'h700 + i), '0, 1'b0);
      tick();
    end
    check_output("t6_level7", 128'(level), 128'(7));
    apply_stimulus(1'b0, '0, '0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("t6_level0", 128'(level), 128'(0));
    check_output("t6_empty", 128'(empty), 128'(1));
    check_output("t6_rdv", 128'(rd_valid), 128'(0));
    check_output("t6_ovf_clr", 128'(ovf_err), 128'(0));
    check_output("t6_udf_clr", 128'(udf_err), 128'(0));
    apply_stimulus(1'b0, '0, '0, 1'b1);
    tick();
    check_output("t6_udf_rdv", 128'(rd_valid), 128'(0));
    check_output("t6_udf_level", 128'(level), 128'(0));
    check_output("t6_udf", 128'(udf_err), 128'(ERR_ON));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
